// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port arbiter (recorder write / player read) in front of an
// asynchronous 16-bit SRAM. Each access holds registered strobes for
// ACC_CYCLES cycles, then returns to IDLE with a one-cycle ack/valid pulse.
// Requests seen during that pulse cycle are ignored, so a requester that drops
// its request on ack is never served twice.
module sram_arbiter #(
  parameter int unsigned ACC_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wr_req,
  input  logic [19:0] i_wr_addr,
  input  logic [15:0] i_wr_data,
  output logic        o_wr_ack,
  input  logic        i_rd_req,
  input  logic [19:0] i_rd_addr,
  output logic [15:0] o_rd_data,
  output logic        o_rd_valid,
  output logic        o_busy,
  output logic [19:0] o_SRAM_ADDR,
  inout  logic [15:0] io_SRAM_DQ,
  output logic        o_SRAM_WE_N,
  output logic        o_SRAM_CE_N,
  output logic        o_SRAM_OE_N,
  output logic        o_SRAM_LB_N,
  output logic        o_SRAM_UB_N
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;

  // Last counter value of an access: the edge with cnt_q == CNT_LAST leaves.
  localparam logic [3:0] CNT_LAST = 4'(ACC_CYCLES - 1);

  localparam logic GRANT_WR = 1'b0;
  localparam logic GRANT_RD = 1'b1;

  logic [1:0]  state_q,      state_d;
  logic [3:0]  cnt_q,        cnt_d;
  logic [19:0] addr_q,       addr_d;
  logic [15:0] wdata_q,      wdata_d;
  logic [15:0] rd_data_q,    rd_data_d;
  logic        wr_ack_q,     wr_ack_d;
  logic        rd_valid_q,   rd_valid_d;
  logic        last_grant_q, last_grant_d;
  logic        ce_n_q,       ce_n_d;
  logic        we_n_q,       we_n_d;
  logic        oe_n_q,       oe_n_d;
  logic        lb_n_q,       lb_n_d;
  logic        ub_n_q,       ub_n_d;
  logic        dq_oe_q,      dq_oe_d;

  logic        gap;
  logic        grant_wr;
  logic        grant_rd;

  // Next-state logic: arbitration in IDLE, access timing in WRITE/READ.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rd_data_d    = rd_data_q;
    wr_ack_d     = 1'b0;
    rd_valid_d   = 1'b0;
    last_grant_d = last_grant_q;
    ce_n_d       = ce_n_q;
    we_n_d       = we_n_q;
    oe_n_d       = oe_n_q;
    lb_n_d       = lb_n_q;
    ub_n_d       = ub_n_q;
    dq_oe_d      = dq_oe_q;

    // The ack/valid cycle is a mandatory idle gap: no new grant at its end.
    gap      = wr_ack_q | rd_valid_q;
    grant_wr = 1'b0;
    grant_rd = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!gap) begin
          // Round-robin on a tie: whoever was not granted last wins.
          grant_wr = i_wr_req && (!i_rd_req || (last_grant_q == GRANT_RD));
          grant_rd = i_rd_req && (!i_wr_req || (last_grant_q == GRANT_WR));
        end
        if (grant_wr) begin
          state_d      = ST_WRITE;
          cnt_d        = '0;
          addr_d       = i_wr_addr;
          wdata_d      = i_wr_data;
          last_grant_d = GRANT_WR;
          ce_n_d       = 1'b0;
          we_n_d       = 1'b0;
          oe_n_d       = 1'b1;
          lb_n_d       = 1'b0;
          ub_n_d       = 1'b0;
          dq_oe_d      = 1'b1;
        end else if (grant_rd) begin
          state_d      = ST_READ;
          cnt_d        = '0;
          addr_d       = i_rd_addr;
          last_grant_d = GRANT_RD;
          ce_n_d       = 1'b0;
          we_n_d       = 1'b1;
          oe_n_d       = 1'b0;
          lb_n_d       = 1'b0;
          ub_n_d       = 1'b0;
          dq_oe_d      = 1'b0;
        end
      end

      ST_WRITE, ST_READ: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          ce_n_d  = 1'b1;
          we_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          lb_n_d  = 1'b1;
          ub_n_d  = 1'b1;
          dq_oe_d = 1'b0;
          if (state_q == ST_WRITE) begin
            wr_ack_d = 1'b1;
          end else begin
            rd_valid_d = 1'b1;
            rd_data_d  = io_SRAM_DQ;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        ce_n_d  = 1'b1;
        we_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        lb_n_d  = 1'b1;
        ub_n_d  = 1'b1;
        dq_oe_d = 1'b0;
      end
    endcase
  end

  // State and registered strobes; reset aborts any access immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_data_q    <= '0;
      wr_ack_q     <= 1'b0;
      rd_valid_q   <= 1'b0;
      last_grant_q <= GRANT_RD;
      ce_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      lb_n_q       <= 1'b1;
      ub_n_q       <= 1'b1;
      dq_oe_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_data_q    <= rd_data_d;
      wr_ack_q     <= wr_ack_d;
      rd_valid_q   <= rd_valid_d;
      last_grant_q <= last_grant_d;
      ce_n_q       <= ce_n_d;
      we_n_q       <= we_n_d;
      oe_n_q       <= oe_n_d;
      lb_n_q       <= lb_n_d;
      ub_n_q       <= ub_n_d;
      dq_oe_q      <= dq_oe_d;
    end
  end

  assign io_SRAM_DQ  = dq_oe_q ? wdata_q : 'z;
  assign o_SRAM_ADDR = addr_q;
  assign o_SRAM_WE_N = we_n_q;
  assign o_SRAM_CE_N = ce_n_q;
  assign o_SRAM_OE_N = oe_n_q;
  assign o_SRAM_LB_N = lb_n_q;
  assign o_SRAM_UB_N = ub_n_q;
  assign o_rd_data   = rd_data_q;
  assign o_rd_valid  = rd_valid_q;
  assign o_wr_ack    = wr_ack_q;
  assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: table of single accesses on an ACC_CYCLES=2 build,
// hand sequences for back-to-back reads, reset mid-write and contention, and
// a single read on an ACC_CYCLES=1 build. Pull-ups make an undriven bus FFFF.
module tb_sram_arbiter;

  localparam int unsigned ACC = 2;

  // {ce_n, we_n, oe_n, lb_n, ub_n}
  localparam logic [4:0] S_IDLE = 5'b11111;
  localparam logic [4:0] S_WR   = 5'b00100;
  localparam logic [4:0] S_RD   = 5'b01000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ACC_CYCLES = 2 instance
  logic        wr_req = 1'b0, rd_req = 1'b0;
  logic [19:0] wr_addr = '0, rd_addr = '0;
  logic [15:0] wr_data = '0;
  logic        wr_ack, rd_valid, busy;
  logic [15:0] rd_data;
  logic [19:0] sram_addr;
  logic        we_n, ce_n, oe_n, lb_n, ub_n;
  wire  [15:0] dq;

  // ACC_CYCLES = 1 instance
  logic        wr_req1 = 1'b0, rd_req1 = 1'b0;
  logic [19:0] wr_addr1 = '0, rd_addr1 = '0;
  logic [15:0] wr_data1 = '0;
  logic        wr_ack1, rd_valid1, busy1;
  logic [15:0] rd_data1;
  logic [19:0] sram_addr1;
  logic        we_n1, ce_n1, oe_n1, lb_n1, ub_n1;
  wire  [15:0] dq1;

  wire [4:0] strb  = {ce_n, we_n, oe_n, lb_n, ub_n};
  wire [4:0] strb1 = {ce_n1, we_n1, oe_n1, lb_n1, ub_n1};

  sram_arbiter #(.ACC_CYCLES(2)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ack(wr_ack),
    .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_valid(rd_valid),
    .o_busy(busy), .o_SRAM_ADDR(sram_addr), .io_SRAM_DQ(dq),
    .o_SRAM_WE_N(we_n), .o_SRAM_CE_N(ce_n), .o_SRAM_OE_N(oe_n),
    .o_SRAM_LB_N(lb_n), .o_SRAM_UB_N(ub_n)
  );

  sram_arbiter #(.ACC_CYCLES(1)) dut1 (
    .i_clk(clk), .i_rst(rst),
    .i_wr_req(wr_req1), .i_wr_addr(wr_addr1), .i_wr_data(wr_data1), .o_wr_ack(wr_ack1),
    .i_rd_req(rd_req1), .i_rd_addr(rd_addr1), .o_rd_data(rd_data1), .o_rd_valid(rd_valid1),
    .o_busy(busy1), .o_SRAM_ADDR(sram_addr1), .io_SRAM_DQ(dq1),
    .o_SRAM_WE_N(we_n1), .o_SRAM_CE_N(ce_n1), .o_SRAM_OE_N(oe_n1),
    .o_SRAM_LB_N(lb_n1), .o_SRAM_UB_N(ub_n1)
  );

  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup (dq[g]);
    pullup (dq1[g]);
  end

  // SRAM model, partial address decode {addr[19], addr[4:0]}.
  logic [15:0] mem [0:63];
  wire  [5:0]  midx = {sram_addr[19], sram_addr[4:0]};
  assign dq = (!ce_n && !oe_n && we_n) ? mem[midx] : 16'hzzzz;
  always @(posedge clk) if (!ce_n && !we_n) mem[midx] <= dq;

  assign dq1 = (!ce_n1 && !oe_n1 && we_n1) ? 16'h7E57 : 16'hzzzz;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One isolated access; starts at a negedge, ends at the negedge after the gap.
  task automatic access(input logic is_wr, input logic [19:0] a, input logic [15:0] d,
                        input logic [15:0] exp_rd, input string tag);
    if (is_wr) begin wr_req = 1'b1; wr_addr = a; wr_data = d; end
    else begin rd_req = 1'b1; rd_addr = a; end
    for (int unsigned k = 0; k < ACC; k++) begin
      @(negedge clk);
      chk($sformatf("%s c%0d strobes", tag, k), strb, is_wr ? S_WR : S_RD);
      chk($sformatf("%s c%0d addr", tag, k), sram_addr, a);
      chk($sformatf("%s c%0d busy", tag, k), busy, 1);
      chk($sformatf("%s c%0d early done", tag, k), wr_ack | rd_valid, 0);
      if (is_wr) chk($sformatf("%s c%0d dq", tag, k), dq, d);
      // Inputs changing mid-access must not disturb the latched access.
      wr_addr = ~a; wr_data = ~d; rd_addr = ~a;
    end
    @(negedge clk);
    chk({tag, " done strobes"}, strb, S_IDLE);
    chk({tag, " done busy"}, busy, 0);
    chk({tag, " done dq hiz"}, dq, 16'hFFFF);
    chk({tag, " wr_ack"}, wr_ack, is_wr);
    chk({tag, " rd_valid"}, rd_valid, !is_wr);
    if (!is_wr) chk({tag, " rd_data"}, rd_data, exp_rd);
    wr_req = 1'b0; rd_req = 1'b0;
    @(negedge clk);
    chk({tag, " gap pulses"}, {wr_ack, rd_valid}, 0);
    chk({tag, " gap busy"}, busy, 0);
    chk({tag, " gap strobes"}, strb, S_IDLE);
  endtask

  typedef struct {
    logic        is_wr;
    logic [19:0] addr;
    logic [15:0] data;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs [6];
  logic [19:0] b2b_addr [2];
  logic [15:0] b2b_data [2];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    vecs[0] = '{1'b1, 20'h00010, 16'hA5A5, 16'h0000};
    vecs[1] = '{1'b0, 20'h00010, 16'h0000, 16'hA5A5};
    vecs[2] = '{1'b1, 20'hFFFFF, 16'hBEEF, 16'h0000};
    vecs[3] = '{1'b1, 20'h00000, 16'h0F0F, 16'h0000};
    vecs[4] = '{1'b1, 20'h00011, 16'h3C3C, 16'h0000};
    vecs[5] = '{1'b0, 20'h00011, 16'h0000, 16'h3C3C};
    b2b_addr[0] = 20'hFFFFF; b2b_data[0] = 16'hBEEF;
    b2b_addr[1] = 20'h00000; b2b_data[1] = 16'h0F0F;

    // Reset state
    #1 rst = 1'b1;
    #1;
    chk("rst strobes", strb, S_IDLE);
    chk("rst addr", sram_addr, 0);
    chk("rst rd_data", rd_data, 0);
    chk("rst pulses", {wr_ack, rd_valid}, 0);
    chk("rst busy", busy, 0);
    chk("rst dq hiz", dq, 16'hFFFF);
    chk("rst1 strobes", strb1, S_IDLE);
    chk("rst1 busy", busy1, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("post-rst idle", {busy, strb}, {1'b0, S_IDLE});

    // Table of isolated accesses
    for (int i = 0; i < 6; i++)
      access(vecs[i].is_wr, vecs[i].addr, vecs[i].data, vecs[i].exp_rd, $sformatf("vec%0d", i));

    // Back-to-back reads with the request held across the valid pulse
    rd_req = 1'b1; rd_addr = b2b_addr[0];
    for (int i = 0; i < 2; i++) begin
      for (int unsigned k = 0; k < ACC; k++) begin
        @(negedge clk);
        chk($sformatf("b2b%0d c%0d strobes", i, k), strb, S_RD);
        chk($sformatf("b2b%0d c%0d addr", i, k), sram_addr, b2b_addr[i]);
      end
      @(negedge clk);
      chk($sformatf("b2b%0d valid", i), rd_valid, 1);
      chk($sformatf("b2b%0d data", i), rd_data, b2b_data[i]);
      if (i == 1) rd_req = 1'b0; else rd_addr = b2b_addr[1];
      @(negedge clk);
      chk($sformatf("b2b%0d gap", i), {rd_valid, busy, strb}, {2'b00, S_IDLE});
    end

    // Reset pulsed during cycle 1 of a write
    wr_req = 1'b1; wr_addr = 20'h00005; wr_data = 16'h5A5A;
    @(negedge clk);
    chk("rstmid started", strb, S_WR);
    #1 rst = 1'b1;
    #1;
    chk("rstmid strobes", strb, S_IDLE);
    chk("rstmid dq hiz", dq, 16'hFFFF);
    chk("rstmid busy", busy, 0);
    @(negedge clk);
    chk("rstmid no ack", wr_ack, 0);
    rst = 1'b0;
    access(1'b1, 20'h00005, 16'h5A5A, 16'h0000, "rstmid redo");

    // Contention from reset release: W,R,W,R with ack cycle plus gap between
    rst = 1'b1;
    wr_req = 1'b1; wr_addr = 20'h00006; wr_data = 16'h1111;
    rd_req = 1'b1; rd_addr = 20'h00010;
    @(negedge clk);
    chk("cont in reset busy", busy, 0);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      int  ph;
      logic w;
      ph = k % 4;
      w  = ((k / 4) % 2) == 0;
      @(negedge clk);
      chk($sformatf("cont%0d both pulses", k), wr_ack & rd_valid, 0);
      if (ph < 2) begin
        chk($sformatf("cont%0d strobes", k), strb, w ? S_WR : S_RD);
        chk($sformatf("cont%0d addr", k), sram_addr, w ? 20'h00006 : 20'h00010);
        chk($sformatf("cont%0d busy", k), busy, 1);
      end else if (ph == 2) begin
        chk($sformatf("cont%0d wr_ack", k), wr_ack, w);
        chk($sformatf("cont%0d rd_valid", k), rd_valid, !w);
        if (!w) chk($sformatf("cont%0d rd_data", k), rd_data, 16'hA5A5);
      end else begin
        chk($sformatf("cont%0d gap", k), {wr_ack, rd_valid, busy}, 0);
        if (k == 15) begin wr_req = 1'b0; rd_req = 1'b0; end
      end
    end
    @(negedge clk);
    chk("cont end idle", {busy, strb}, {1'b0, S_IDLE});

    // ACC_CYCLES = 1: single read
    rd_req1 = 1'b1; rd_addr1 = 20'h00040;
    @(negedge clk);
    chk("acc1 strobes", strb1, S_RD);
    chk("acc1 addr", sram_addr1, 20'h00040);
    chk("acc1 busy", busy1, 1);
    chk("acc1 early valid", rd_valid1, 0);
    @(negedge clk);
    chk("acc1 done strobes", strb1, S_IDLE);
    chk("acc1 valid", rd_valid1, 1);
    chk("acc1 data", rd_data1, 16'h7E57);
    chk("acc1 done busy", busy1, 0);
    rd_req1 = 1'b0;
    @(negedge clk);
    chk("acc1 valid pulse", rd_valid1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The module SHALL have parameter ACC_CYCLES, default 2: the number of clock cycles the SRAM strobes are held per access; legal range 1..15.
REQ-002 The module SHALL have ports (clock and reset first):
- i_clk  in  1  system clock; all state changes on the rising edge.
- i_rst  in  1  reset.
- i_wr_req  in  1  recorder write request, level, held until o_wr_ack.
- i_wr_addr  in  20  write word address.
- i_wr_data  in  16  write data.
- o_wr_ack  out  1  one-cycle pulse: write completed.
- i_rd_req  in  1  player read request, level, held until o_rd_valid.
- i_rd_addr  in  20  read word address.
- o_rd_data  out  16  read data, held until the next read completes.
- o_rd_valid  out  1  one-cycle pulse: o_rd_data updated.
- o_busy  out  1  high while an access is in progress.
- o_SRAM_ADDR  out  20  SRAM address.
- io_SRAM_DQ  inout  16  SRAM data bus.
- o_SRAM_WE_N, o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_LB_N, o_SRAM_UB_N  out  1 each  active-low SRAM strobes.
REQ-003 The design SHALL use one clock; reset is asynchronous and active-high.

Function
REQ-004 The controller SHALL implement three states: IDLE, WRITE and READ.
REQ-005 In IDLE, at a rising edge with exactly one request high, the controller SHALL latch that request's address into o_SRAM_ADDR (write data also latched) and enter WRITE or READ.
REQ-006 With both requests high in IDLE, the controller SHALL grant the requester not granted last (round-robin via a last_grant flag), then update last_grant.
REQ-007 WRITE and READ SHALL each last exactly ACC_CYCLES cycles, counted by an internal counter, then return to IDLE.
REQ-008 In WRITE: CE_N, LB_N, UB_N, WE_N low; OE_N high; io_SRAM_DQ driven with the latched data.
REQ-009 In READ: CE_N, LB_N, UB_N, OE_N low; WE_N high; io_SRAM_DQ high-Z.
REQ-010 In IDLE: all strobes high, io_SRAM_DQ high-Z, o_SRAM_ADDR holds its last value.
REQ-011 All strobe outputs SHALL be registered (glitch-free).
REQ-012 At the edge that leaves READ, io_SRAM_DQ SHALL be captured into o_rd_data and o_rd_valid SHALL go high for exactly the following cycle.
REQ-013 At the edge that leaves WRITE, o_wr_ack SHALL go high for exactly the following cycle.
REQ-014 Latency: a request sampled at edge 0 SHALL produce strobes active after edges 0..ACC_CYCLES-1 and ack/valid high after edge ACC_CYCLES.
REQ-015 In the IDLE cycle where o_wr_ack or o_rd_valid is high, the controller SHALL ignore all requests (one idle gap), so a requester deasserting on ack is never double-served.
REQ-016 o_busy SHALL be high exactly when the state is not IDLE.
REQ-017 Request-input changes during WRITE/READ SHALL NOT affect the access in progress; latched address and data are used.

Reset
REQ-018 While i_rst is high, asynchronously: state = IDLE, counter = 0, all strobes high, io_SRAM_DQ high-Z, o_SRAM_ADDR = 0, o_rd_data = 0, o_wr_ack = 0, o_rd_valid = 0, o_busy = 0, last_grant = READ (first tie goes to write).
REQ-019 Reset asserted mid-access SHALL abort the access with no ack/valid; after release, requests still high are arbitrated afresh.

Verification
REQ-020 Single write, ACC_CYCLES=2: wr_req, addr 0x00010, data 0xA5A5 -> WE_N low for 2 cycles, DQ = 0xA5A5, ADDR = 0x00010, o_wr_ack pulse after edge 2.
REQ-021 Read-back: rd_req, addr 0x00010, SRAM model returns 0xA5A5 -> OE_N low for 2 cycles, o_rd_data = 0xA5A5, o_rd_valid one cycle, DQ never driven by DUT.
REQ-022 Contention: both requests held high continuously from reset release -> grants alternate W,R,W,R with one idle cycle between accesses; o_wr_ack and o_rd_valid never high in the same cycle.
REQ-023 Back-to-back reads, addresses 0xFFFFF then 0x00000 -> ADDR wraps correctly, two valid pulses, data matches model.
REQ-024 i_rst pulsed during cycle 1 of a write -> strobes high and DQ high-Z immediately, no o_wr_ack, and after release the held write re-executes fully.
REQ-025 ACC_CYCLES=1 build: single read -> OE_N low for exactly 1 cycle, o_rd_valid after edge 1.
